ysyx_24090012_ifu: RTL and testbench
====================================

# ysyx_24090012_ifu

Instruction fetch stage of the ysyx_24090012 five-stage pipeline, directly upstream of the decode stage. It holds the architectural fetch PC and issues one read per instruction on an AXI4-Lite-style read channel. It presents {inst, pc, num} to decode with a valid/ready handshake. It redirects on the control-hazard signal from decode and discards wrong-path fetches.

## Interface
Parameters:
- RESET_PC, 32'h3000_0000: first fetch address after reset.
- ADDR_W, 32: address and PC width.

Ports:
- clock  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-low reset.
- araddr  out  32  fetch address, equal to the internal PC while arvalid=1.
- arvalid  out  1  read-address valid.
- arready  in  1  read-address ready.
- rdata  in  32  fetched instruction word.
- rresp  in  2  read response; nonzero means error.
- rvalid  in  1  read-data valid.
- rready  out  1  read-data ready.
- inst  out  32  instruction to decode.
- ifu_to_idu_pc  out  32  PC of `inst`.
- num  out  64  instruction sequence tag.
- ifu_valid  out  1  `inst`/pc/num are valid.
- ifu_ready  in  1  decode can accept.
- control_hazard  in  1  redirect request from decode.
- branch_target_pc  in  32  redirect target.
- fetch_err  out  1  sticky; set on a nonzero rresp for a right-path fetch.

## Operation
- FSM states: REQ, WAIT, HOLD.
- REQ: arvalid=1, araddr=pc. On arready, go to WAIT.
- WAIT: rready=1. On rvalid, capture rdata into inst_r, capture pc into pc_r, set num_r <= seq; go to HOLD.
- HOLD: ifu_valid=1. On ifu_valid && ifu_ready: pc <= pc+4, seq <= seq+1; go to REQ.
- Sequence tag: seq resets to 1. Tag 0 is reserved as "no instruction", so the first delivered instruction carries num=1. seq wraps modulo 2^64 and skips 0 on wrap.
- Redirect (control_hazard=1) has priority over every other event in the same cycle:
  - REQ, arready=0: pc <= branch_target_pc, stay in REQ. Mid-request address change is permitted.
  - REQ, arready=1: pc <= target; set drop=1; go to WAIT.
  - WAIT, no rvalid: pc <= target; set drop=1.
  - WAIT with rvalid: pc <= target; discard the response; go to REQ.
  - HOLD: pc <= target; ifu_valid drops the next cycle; go to REQ. A concurrent decode handshake in that cycle still transfers; seq still advances.
- WAIT with drop=1: on rvalid, discard the data, clear drop, go to REQ. No output update, no fetch_err.
- rresp≠0 on a right-path response: set fetch_err; still deliver the word.
- PC arithmetic is modulo 2^32. pc+4 wraps from 32'hFFFF_FFFC to 0.

## Timing
- Reset (reset=0 at posedge) values: state=REQ, pc=RESET_PC, seq=1, inst=0, ifu_to_idu_pc=0, num=0, ifu_valid=0, arvalid=0, rready=0, fetch_err=0, drop=0.
- arvalid is registered from the state and asserts in the first cycle after reset is released.
- Reset asserted mid-transaction aborts everything. An rvalid that arrives after reset is not tracked; the bus side must also be reset.
- Latency with zero-wait memory: arvalid@t, arready@t, rvalid@t+1, ifu_valid@t+2. Steady state is one instruction per 3 cycles.
- Outputs hold stable while ifu_valid=1 and ifu_ready=0.
- control_hazard is sampled on every cycle, not only while ifu_valid=1.

## Configuration
- IFU_PERF_EN defined: adds 32-bit counters fetch_cnt (right-path responses), flush_cnt (redirects), and stall_cnt (cycles in HOLD with ifu_ready=0).
  - All three reset to 0 and saturate at all-ones.
  - They are exposed as output ports perf_fetch, perf_flush, perf_stall.
- IFU_PERF_EN undefined: the counters and ports are absent. Functional behaviour is identical.

## Structure
- Shared package ysyx_24090012_pkg holds:
  - FSM state encoding: IFU_REQ, IFU_WAIT, IFU_HOLD.
  - RESP_OKAY=2'b00.
  - NUM_W=64.
- Sub-module ysyx_24090012_ifu_perf contains the three saturating counters. It is instantiated only under IFU_PERF_EN.
- Everything else stays in one flat module.

## Test plan
- Reset then free-run:
  - Stimulus: zero-wait memory returning pc-indexed words.
  - Required: araddr sequence is 3000_0000, 3000_0004, 3000_0008…; num is 1, 2, 3; ifu_valid is high in every third cycle.
- Decode backpressure:
  - Stimulus: hold ifu_ready=0 for 5 cycles in HOLD.
  - Required: inst, pc and num are stable; no new arvalid; after ready, the next araddr is pc+4.
- Redirect in WAIT:
  - Stimulus: control_hazard=1 with target 3000_0100 while waiting; the response arrives 2 cycles later.
  - Required: the response is discarded; the next araddr is 3000_0100; num continues without a gap.
- Redirect in HOLD with a same-cycle handshake:
  - Stimulus: as described.
  - Required: the instruction transfers once; the next fetch address is the target, not pc+4.
- Error response:
  - Stimulus: rresp=2'b10 on a right-path fetch.
  - Required: fetch_err=1 and stays set; the word is still delivered.
  - Stimulus: rresp=2'b10 on a dropped fetch.
  - Required: fetch_err stays 0.
- Wrap and reset:
  - Stimulus: RESET_PC=32'hFFFF_FFFC.
  - Required: the second fetch address is 0.
  - Stimulus: assert reset in WAIT.
  - Required: all outputs return to their reset values the next cycle.

Source files
------------

// File: rtl/ysyx_24090012_pkg.sv
// ysyx_24090012_pkg: types and constants shared by the ysyx_24090012 pipeline stages.
// Holds the fetch FSM encoding, the AXI "OKAY" response code and the width of
// the instruction sequence tag, plus the tag increment helper.
package ysyx_24090012_pkg;

    typedef enum logic [1:0] {
        IFU_REQ  = 2'd0,
        IFU_WAIT = 2'd1,
        IFU_HOLD = 2'd2
    } ifu_state_e;

    localparam logic [1:0] RESP_OKAY = 2'b00;
    localparam int         NUM_W     = 64;

    // Tag 0 means "no instruction", so the increment skips it when the counter wraps.
    function automatic logic [NUM_W-1:0] nextSeq(input logic [NUM_W-1:0] seq);
        logic [NUM_W-1:0] incr;
        incr = seq + {{(NUM_W-1){1'b0}}, 1'b1};
        return (incr == '0) ? {{(NUM_W-1){1'b0}}, 1'b1} : incr;
    endfunction

endpackage

// File: rtl/ysyx_24090012_ifu_perf.sv
// ysyx_24090012_ifu_perf: three saturating 32-bit event counters for the fetch stage.
// Only instantiated when IFU_PERF_EN is defined.
module ysyx_24090012_ifu_perf
    import ysyx_24090012_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        incFetch_i,
    input  logic        incFlush_i,
    input  logic        incStall_i,
    output logic [31:0] fetchCnt_o,
    output logic [31:0] flushCnt_o,
    output logic [31:0] stallCnt_o
);

    logic [31:0] fetchCnt_q, fetchCnt_d;
    logic [31:0] flushCnt_q, flushCnt_d;
    logic [31:0] stallCnt_q, stallCnt_d;

    // Each counter increments on its event and sticks at all-ones instead of wrapping.
    always_comb begin
        fetchCnt_d = fetchCnt_q;
        flushCnt_d = flushCnt_q;
        stallCnt_d = stallCnt_q;
        if (incFetch_i && (fetchCnt_q != '1)) fetchCnt_d = fetchCnt_q + 32'd1;
        if (incFlush_i && (flushCnt_q != '1)) flushCnt_d = flushCnt_q + 32'd1;
        if (incStall_i && (stallCnt_q != '1)) stallCnt_d = stallCnt_q + 32'd1;
    end

    // Counter registers with synchronous active-low clear.
    always_ff @(posedge clock) begin
        if (!reset) begin
            fetchCnt_q <= '0;
            flushCnt_q <= '0;
            stallCnt_q <= '0;
        end else begin
            fetchCnt_q <= fetchCnt_d;
            flushCnt_q <= flushCnt_d;
            stallCnt_q <= stallCnt_d;
        end
    end

    assign fetchCnt_o = fetchCnt_q;
    assign flushCnt_o = flushCnt_q;
    assign stallCnt_o = stallCnt_q;

endmodule

// File: rtl/ysyx_24090012_ifu.sv
// ysyx_24090012_ifu: instruction fetch stage. Holds the fetch PC, issues one
// AXI4-Lite-style read per instruction and hands {inst, pc, num} to decode.
// Redirects from decode override everything else; a fetch already on the bus
// when a redirect arrives is tracked with the drop flag and discarded.
// Optional macro IFU_PERF_EN adds saturating fetch/flush/stall counters.
module ysyx_24090012_ifu
    import ysyx_24090012_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h3000_0000
) (
    input  logic              clock,
    input  logic              reset,
    output logic [ADDR_W-1:0] araddr,
    output logic              arvalid,
    input  logic              arready,
    input  logic [31:0]       rdata,
    input  logic [1:0]        rresp,
    input  logic              rvalid,
    output logic              rready,
    output logic [31:0]       inst,
    output logic [ADDR_W-1:0] ifu_to_idu_pc,
    output logic [NUM_W-1:0]  num,
    output logic              ifu_valid,
    input  logic              ifu_ready,
    input  logic              control_hazard,
    input  logic [ADDR_W-1:0] branch_target_pc,
    output logic              fetch_err
`ifdef IFU_PERF_EN
    ,
    output logic [31:0]       perf_fetch,
    output logic [31:0]       perf_flush,
    output logic [31:0]       perf_stall
`endif
);

    ifu_state_e        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [NUM_W-1:0]  seq_q, seq_d;
    logic              drop_q, drop_d;
    logic [31:0]       inst_q, inst_d;
    logic [ADDR_W-1:0] idPc_q, idPc_d;
    logic [NUM_W-1:0]  num_q, num_d;
    logic              fetchErr_q, fetchErr_d;
    logic              arvalid_q, rready_q, ifuValid_q;

    logic reqFire, respFire, outFire, rightPath;

    // Handshakes are qualified by the registered valid/ready outputs, so the
    // cycle right after reset (state REQ but arvalid still low) cannot fire.
    always_comb begin
        reqFire   = (state_q == IFU_REQ)  && arvalid_q  && arready;
        respFire  = (state_q == IFU_WAIT) && rready_q   && rvalid;
        outFire   = (state_q == IFU_HOLD) && ifuValid_q && ifu_ready;
        rightPath = respFire && !drop_q && !control_hazard;
    end

    // Next-state logic: normal REQ->WAIT->HOLD progression, with a redirect
    // applied last so it overrides the PC and state chosen by any other event.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        seq_d      = seq_q;
        drop_d     = drop_q;
        inst_d     = inst_q;
        idPc_d     = idPc_q;
        num_d      = num_q;
        fetchErr_d = fetchErr_q;
        case (state_q)
            IFU_REQ: begin
                if (reqFire) state_d = IFU_WAIT;
                if (control_hazard) begin
                    pc_d = branch_target_pc;
                    if (reqFire) drop_d = 1'b1;
                end
            end
            IFU_WAIT: begin
                if (respFire) begin
                    drop_d  = 1'b0;
                    state_d = IFU_REQ;
                    if (rightPath) begin
                        inst_d  = rdata;
                        idPc_d  = pc_q;
                        num_d   = seq_q;
                        state_d = IFU_HOLD;
                        if (rresp != RESP_OKAY) fetchErr_d = 1'b1;
                    end
                end
                if (control_hazard) begin
                    pc_d = branch_target_pc;
                    if (!respFire) drop_d = 1'b1;
                end
            end
            IFU_HOLD: begin
                if (outFire) begin
                    seq_d   = nextSeq(seq_q);
                    pc_d    = pc_q + ADDR_W'(4);
                    state_d = IFU_REQ;
                end
                if (control_hazard) begin
                    pc_d    = branch_target_pc;
                    state_d = IFU_REQ;
                end
            end
            default: state_d = IFU_REQ;
        endcase
    end

    // State and output registers; bus/decode valids are registered from the next state.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= IFU_REQ;
            pc_q       <= RESET_PC;
            seq_q      <= {{(NUM_W-1){1'b0}}, 1'b1};
            drop_q     <= 1'b0;
            inst_q     <= '0;
            idPc_q     <= '0;
            num_q      <= '0;
            fetchErr_q <= 1'b0;
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b0;
            ifuValid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            seq_q      <= seq_d;
            drop_q     <= drop_d;
            inst_q     <= inst_d;
            idPc_q     <= idPc_d;
            num_q      <= num_d;
            fetchErr_q <= fetchErr_d;
            arvalid_q  <= (state_d == IFU_REQ);
            rready_q   <= (state_d == IFU_WAIT);
            ifuValid_q <= (state_d == IFU_HOLD);
        end
    end

    assign araddr        = pc_q;
    assign arvalid       = arvalid_q;
    assign rready        = rready_q;
    assign inst          = inst_q;
    assign ifu_to_idu_pc = idPc_q;
    assign num           = num_q;
    assign ifu_valid     = ifuValid_q;
    assign fetch_err     = fetchErr_q;

`ifdef IFU_PERF_EN
    logic incStall;

    // A stall cycle is one where decode is offered an instruction and refuses it.
    always_comb begin
        incStall = (state_q == IFU_HOLD) && ifuValid_q && !ifu_ready;
    end

    ysyx_24090012_ifu_perf uPerf (
        .clock      (clock),
        .reset      (reset),
        .incFetch_i (rightPath),
        .incFlush_i (control_hazard),
        .incStall_i (incStall),
        .fetchCnt_o (perf_fetch),
        .flushCnt_o (perf_flush),
        .stallCnt_o (perf_stall)
    );
`endif

endmodule

// File: tb/tb_ysyx_24090012_ifu.sv
// tb_ysyx_24090012_ifu: directed self-checking bench for the fetch stage.
// A second instance with RESET_PC=FFFF_FFFC exercises PC wrap-around.
module tb_ysyx_24090012_ifu;

    logic        clock = 1'b0;
    logic        reset = 1'b0;

    logic [31:0] araddr;
    logic        arvalid;
    logic        arready = 1'b0;
    logic [31:0] rdata = '0;
    logic [1:0]  rresp = 2'b00;
    logic        rvalid = 1'b0;
    logic        rready;
    logic [31:0] inst;
    logic [31:0] ifuPc;
    logic [63:0] num;
    logic        ifu_valid;
    logic        ifu_ready = 1'b0;
    logic        control_hazard = 1'b0;
    logic [31:0] branch_target_pc = '0;
    logic        fetch_err;

    logic [31:0] wAraddr;
    logic        wArvalid;
    logic        wArready = 1'b0;
    logic [31:0] wRdata = '0;
    logic        wRvalid = 1'b0;
    logic        wRready;
    logic [31:0] wInst;
    logic [31:0] wPc;
    logic [63:0] wNum;
    logic        wIfuValid;
    logic        wIfuReady = 1'b0;
    logic        wFetchErr;

    int nCompared = 0;
    int nMismatched = 0;

    always #5 clock = ~clock;

    ysyx_24090012_ifu dut (
        .clock            (clock),
        .reset            (reset),
        .araddr           (araddr),
        .arvalid          (arvalid),
        .arready          (arready),
        .rdata            (rdata),
        .rresp            (rresp),
        .rvalid           (rvalid),
        .rready           (rready),
        .inst             (inst),
        .ifu_to_idu_pc    (ifuPc),
        .num              (num),
        .ifu_valid        (ifu_valid),
        .ifu_ready        (ifu_ready),
        .control_hazard   (control_hazard),
        .branch_target_pc (branch_target_pc),
        .fetch_err        (fetch_err)
    );

    ysyx_24090012_ifu #(.RESET_PC(32'hFFFF_FFFC)) dutWrap (
        .clock            (clock),
        .reset            (reset),
        .araddr           (wAraddr),
        .arvalid          (wArvalid),
        .arready          (wArready),
        .rdata            (wRdata),
        .rresp            (2'b00),
        .rvalid           (wRvalid),
        .rready           (wRready),
        .inst             (wInst),
        .ifu_to_idu_pc    (wPc),
        .num              (wNum),
        .ifu_valid        (wIfuValid),
        .ifu_ready        (wIfuReady),
        .control_hazard   (1'b0),
        .branch_target_pc (32'h0),
        .fetch_err        (wFetchErr)
    );

    // Advance one clock and settle just past the edge before sampling or driving.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Accept the outstanding request this cycle, then return word ~addr next cycle.
    task automatic applyStimulus(input logic [31:0] addr, input logic [1:0] resp);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        rvalid = 1'b1;
        rdata = ~addr;
        rresp = resp;
        tick();
        rvalid = 1'b0;
        rresp = 2'b00;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        nCompared++;
        if ({arvalid, rready, ifu_valid, fetch_err} !== 4'b0000) begin
            nMismatched++;
            $display("[TB] FAIL reset_ctrl got %b want 0000", {arvalid, rready, ifu_valid, fetch_err});
        end
        nCompared++;
        if ({inst, ifuPc, num} !== 128'd0) begin
            nMismatched++;
            $display("[TB] FAIL reset_data got %h want 0", {inst, ifuPc, num});
        end
        reset = 1'b1;
        tick();
        nCompared++;
        if ({arvalid, araddr} !== {1'b1, 32'h3000_0000}) begin
            nMismatched++;
            $display("[TB] FAIL reset_first_req got %h want %h", {arvalid, araddr}, {1'b1, 32'h3000_0000});
        end
    endtask

    task automatic test_free_run();
        logic [31:0] addr;
        ifu_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            addr = 32'h3000_0000 + 32'(4 * k);
            nCompared++;
            if ({arvalid, araddr} !== {1'b1, addr}) begin
                nMismatched++;
                $display("[TB] FAIL free_req k=%0d got %h want %h", k, {arvalid, araddr}, {1'b1, addr});
            end
            arready = 1'b1;
            tick();
            arready = 1'b0;
            nCompared++;
            if ({rready, ifu_valid, arvalid} !== 3'b100) begin
                nMismatched++;
                $display("[TB] FAIL free_wait k=%0d got %b want 100", k, {rready, ifu_valid, arvalid});
            end
            rvalid = 1'b1;
            rdata = ~addr;
            tick();
            rvalid = 1'b0;
            nCompared++;
            if ({ifu_valid, inst, ifuPc, num} !== {1'b1, ~addr, addr, 64'(k + 1)}) begin
                nMismatched++;
                $display("[TB] FAIL free_out k=%0d got %h want %h", k, {ifu_valid, inst, ifuPc, num}, {1'b1, ~addr, addr, 64'(k + 1)});
            end
            tick();
            nCompared++;
            if (ifu_valid !== 1'b0) begin
                nMismatched++;
                $display("[TB] FAIL free_valid_drop k=%0d got %b want 0", k, ifu_valid);
            end
        end
    endtask

    task automatic test_backpressure();
        ifu_ready = 1'b0;
        applyStimulus(32'h3000_000C, 2'b00);
        for (int i = 0; i < 5; i++) begin
            nCompared++;
            if ({arvalid, ifu_valid, inst, ifuPc, num} !== {1'b0, 1'b1, ~32'h3000_000C, 32'h3000_000C, 64'd4}) begin
                nMismatched++;
                $display("[TB] FAIL bp_hold i=%0d got %h want %h", i, {arvalid, ifu_valid, inst, ifuPc, num}, {1'b0, 1'b1, ~32'h3000_000C, 32'h3000_000C, 64'd4});
            end
            tick();
        end
        ifu_ready = 1'b1;
        tick();
        nCompared++;
        if ({ifu_valid, arvalid, araddr} !== {1'b0, 1'b1, 32'h3000_0010}) begin
            nMismatched++;
            $display("[TB] FAIL bp_next_req got %h want %h", {ifu_valid, arvalid, araddr}, {1'b0, 1'b1, 32'h3000_0010});
        end
    endtask

    task automatic test_redirect_wait();
        arready = 1'b1;
        tick();
        arready = 1'b0;
        control_hazard = 1'b1;
        branch_target_pc = 32'h3000_0100;
        tick();
        control_hazard = 1'b0;
        tick();
        rvalid = 1'b1;
        rdata = 32'hDEAD_BEEF;
        rresp = 2'b10;
        tick();
        rvalid = 1'b0;
        rresp = 2'b00;
        nCompared++;
        if ({arvalid, araddr, ifu_valid, fetch_err} !== {1'b1, 32'h3000_0100, 1'b0, 1'b0}) begin
            nMismatched++;
            $display("[TB] FAIL rw_discard got %h want %h", {arvalid, araddr, ifu_valid, fetch_err}, {1'b1, 32'h3000_0100, 1'b0, 1'b0});
        end
        nCompared++;
        if ({inst, ifuPc, num} !== {~32'h3000_000C, 32'h3000_000C, 64'd4}) begin
            nMismatched++;
            $display("[TB] FAIL rw_outputs_kept got %h want %h", {inst, ifuPc, num}, {~32'h3000_000C, 32'h3000_000C, 64'd4});
        end
        applyStimulus(32'h3000_0100, 2'b00);
        nCompared++;
        if ({ifu_valid, inst, ifuPc, num} !== {1'b1, ~32'h3000_0100, 32'h3000_0100, 64'd5}) begin
            nMismatched++;
            $display("[TB] FAIL rw_target_out got %h want %h", {ifu_valid, inst, ifuPc, num}, {1'b1, ~32'h3000_0100, 32'h3000_0100, 64'd5});
        end
        tick();
    endtask

    task automatic test_redirect_hold();
        applyStimulus(32'h3000_0104, 2'b00);
        nCompared++;
        if ({ifu_valid, ifuPc, num} !== {1'b1, 32'h3000_0104, 64'd6}) begin
            nMismatched++;
            $display("[TB] FAIL rh_out got %h want %h", {ifu_valid, ifuPc, num}, {1'b1, 32'h3000_0104, 64'd6});
        end
        control_hazard = 1'b1;
        branch_target_pc = 32'h3000_0200;
        tick();
        control_hazard = 1'b0;
        nCompared++;
        if ({ifu_valid, arvalid, araddr} !== {1'b0, 1'b1, 32'h3000_0200}) begin
            nMismatched++;
            $display("[TB] FAIL rh_target_req got %h want %h", {ifu_valid, arvalid, araddr}, {1'b0, 1'b1, 32'h3000_0200});
        end
        applyStimulus(32'h3000_0200, 2'b00);
        nCompared++;
        if ({ifu_valid, inst, ifuPc, num} !== {1'b1, ~32'h3000_0200, 32'h3000_0200, 64'd7}) begin
            nMismatched++;
            $display("[TB] FAIL rh_next_out got %h want %h", {ifu_valid, inst, ifuPc, num}, {1'b1, ~32'h3000_0200, 32'h3000_0200, 64'd7});
        end
        tick();
    endtask

    task automatic test_error();
        applyStimulus(32'h3000_0204, 2'b10);
        nCompared++;
        if ({fetch_err, ifu_valid, inst, num} !== {1'b1, 1'b1, ~32'h3000_0204, 64'd8}) begin
            nMismatched++;
            $display("[TB] FAIL err_set got %h want %h", {fetch_err, ifu_valid, inst, num}, {1'b1, 1'b1, ~32'h3000_0204, 64'd8});
        end
        tick();
        applyStimulus(32'h3000_0208, 2'b00);
        nCompared++;
        if ({fetch_err, ifuPc, num} !== {1'b1, 32'h3000_0208, 64'd9}) begin
            nMismatched++;
            $display("[TB] FAIL err_sticky got %h want %h", {fetch_err, ifuPc, num}, {1'b1, 32'h3000_0208, 64'd9});
        end
        tick();
    endtask

    task automatic test_redirect_req();
        control_hazard = 1'b1;
        branch_target_pc = 32'h3000_0300;
        tick();
        nCompared++;
        if ({arvalid, araddr} !== {1'b1, 32'h3000_0300}) begin
            nMismatched++;
            $display("[TB] FAIL rq_retarget got %h want %h", {arvalid, araddr}, {1'b1, 32'h3000_0300});
        end
        branch_target_pc = 32'h3000_0400;
        arready = 1'b1;
        tick();
        arready = 1'b0;
        control_hazard = 1'b0;
        nCompared++;
        if ({rready, arvalid} !== 2'b10) begin
            nMismatched++;
            $display("[TB] FAIL rq_wait got %b want 10", {rready, arvalid});
        end
        rvalid = 1'b1;
        rdata = 32'h1234_5678;
        tick();
        rvalid = 1'b0;
        nCompared++;
        if ({arvalid, araddr, ifu_valid, num} !== {1'b1, 32'h3000_0400, 1'b0, 64'd9}) begin
            nMismatched++;
            $display("[TB] FAIL rq_dropped got %h want %h", {arvalid, araddr, ifu_valid, num}, {1'b1, 32'h3000_0400, 1'b0, 64'd9});
        end
    endtask

    task automatic test_reset_mid();
        arready = 1'b1;
        tick();
        arready = 1'b0;
        reset = 1'b0;
        tick();
        nCompared++;
        if ({arvalid, rready, ifu_valid, fetch_err, inst, ifuPc, num} !== 132'd0) begin
            nMismatched++;
            $display("[TB] FAIL rst_mid got %h want 0", {arvalid, rready, ifu_valid, fetch_err, inst, ifuPc, num});
        end
        reset = 1'b1;
        tick();
        nCompared++;
        if ({arvalid, araddr} !== {1'b1, 32'h3000_0000}) begin
            nMismatched++;
            $display("[TB] FAIL rst_mid_req got %h want %h", {arvalid, araddr}, {1'b1, 32'h3000_0000});
        end
        applyStimulus(32'h3000_0000, 2'b00);
        nCompared++;
        if ({ifu_valid, num} !== {1'b1, 64'd1}) begin
            nMismatched++;
            $display("[TB] FAIL rst_mid_seq got %h want %h", {ifu_valid, num}, {1'b1, 64'd1});
        end
    endtask

    task automatic test_wrap();
        nCompared++;
        if ({wArvalid, wAraddr} !== {1'b1, 32'hFFFF_FFFC}) begin
            nMismatched++;
            $display("[TB] FAIL wrap_first got %h want %h", {wArvalid, wAraddr}, {1'b1, 32'hFFFF_FFFC});
        end
        wArready = 1'b1;
        tick();
        wArready = 1'b0;
        wRvalid = 1'b1;
        wRdata = 32'h0000_0013;
        tick();
        wRvalid = 1'b0;
        nCompared++;
        if ({wIfuValid, wInst, wPc, wNum} !== {1'b1, 32'h0000_0013, 32'hFFFF_FFFC, 64'd1}) begin
            nMismatched++;
            $display("[TB] FAIL wrap_out got %h want %h", {wIfuValid, wInst, wPc, wNum}, {1'b1, 32'h0000_0013, 32'hFFFF_FFFC, 64'd1});
        end
        wIfuReady = 1'b1;
        tick();
        nCompared++;
        if ({wArvalid, wAraddr, wFetchErr} !== {1'b1, 32'h0000_0000, 1'b0}) begin
            nMismatched++;
            $display("[TB] FAIL wrap_second got %h want %h", {wArvalid, wAraddr, wFetchErr}, {1'b1, 32'h0000_0000, 1'b0});
        end
    endtask

    // Run every scenario in order; each one leaves the main instance in REQ for the next.
    initial begin
        test_reset();
        test_free_run();
        test_backpressure();
        test_redirect_wait();
        test_redirect_hold();
        test_error();
        test_redirect_req();
        test_reset_mid();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
